// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB requester arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_arb_state_t;

  // Low bit of requester idx's field inside a packed per-requester bus.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after 'last' and wraps.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic          w_found;
  logic [LW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // k = N revisits 'last' itself, so it only wins when nobody else asks.
    for (int k = 1; k <= N; k++) begin
      w_idx = LW'((int'(last) + k) % N);
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_gpio_arb.sv
// Round-robin APB4 arbiter: MASTERS requesters share one APB4 slave; the winner's
// transfer is replayed on the registered m-side port and its result routed back.
module apb_gpio_arb
  import apb_arb_pkg::*;
#(
  parameter int MASTERS    = 2,
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 8
) (
  input  logic                            PRESETn,
  input  logic                            PCLK,
  input  logic [MASTERS-1:0]              s_PSEL,
  input  logic [MASTERS-1:0]              s_PENABLE,
  input  logic [MASTERS*PADDR_SIZE-1:0]   s_PADDR,
  input  logic [MASTERS-1:0]              s_PWRITE,
  input  logic [MASTERS*PDATA_SIZE/8-1:0] s_PSTRB,
  input  logic [MASTERS*PDATA_SIZE-1:0]   s_PWDATA,
  output logic [PDATA_SIZE-1:0]           s_PRDATA,
  output logic [MASTERS-1:0]              s_PREADY,
  output logic [MASTERS-1:0]              s_PSLVERR,
  output logic                            m_PSEL,
  output logic                            m_PENABLE,
  output logic                            m_PWRITE,
  output logic [PADDR_SIZE-1:0]           m_PADDR,
  output logic [PDATA_SIZE/8-1:0]         m_PSTRB,
  output logic [PDATA_SIZE-1:0]           m_PWDATA,
  input  logic [PDATA_SIZE-1:0]           m_PRDATA,
  input  logic                            m_PREADY,
  input  logic                            m_PSLVERR,
  output logic [MASTERS-1:0]              gnt_o
);

  localparam int LW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int SW = PDATA_SIZE / 8;

  apb_arb_state_t          r_state, w_next;
  logic [MASTERS-1:0]      r_gnt, w_req, w_arb_gnt;
  logic [LW-1:0]           r_last, w_idx;
  logic                    w_load, w_done;
  logic                    r_psel, r_pen, r_pwrite, w_pwrite;
  logic [PADDR_SIZE-1:0]   r_paddr, w_paddr;
  logic [SW-1:0]           r_pstrb, w_pstrb;
  logic [PDATA_SIZE-1:0]   r_pwdata, w_pwdata;
  logic                    w_unused;

  // Requests are qualified by PSEL alone; PENABLE carries no extra information here.
  assign w_unused = ^s_PENABLE;

  assign w_done = (r_state == ACCESS) && m_PREADY;
  // The completing requester still holds PSEL this cycle; keep it out of the next pick.
  assign w_req  = (r_state == ACCESS) ? (s_PSEL & ~r_gnt) : s_PSEL;

  rr_arbiter #(.N(MASTERS)) u_rr (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_arb_gnt)
  );

  always_comb begin
    w_idx    = '0;
    w_paddr  = '0;
    w_pwrite = 1'b0;
    w_pstrb  = '0;
    w_pwdata = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (w_arb_gnt[i]) begin
        w_idx    = LW'(i);
        w_paddr  = s_PADDR[slice_lo(i, PADDR_SIZE) +: PADDR_SIZE];
        w_pwrite = s_PWRITE[i];
        w_pstrb  = s_PSTRB[slice_lo(i, SW) +: SW];
        w_pwdata = s_PWDATA[slice_lo(i, PDATA_SIZE) +: PDATA_SIZE];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_next = SETUP;
          w_load = 1'b1;
        end
      end
      SETUP:  w_next = ACCESS;
      ACCESS: begin
        if (m_PREADY) begin
          if (|w_req) begin
            w_next = SETUP;
            w_load = 1'b1;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_last   <= LW'(MASTERS - 1);
      r_psel   <= 1'b0;
      r_pen    <= 1'b0;
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pstrb  <= '0;
      r_pwdata <= '0;
    end else begin
      r_state <= w_next;
      r_psel  <= (w_next != IDLE);
      r_pen   <= (w_next == ACCESS);
      if (w_load) begin
        r_gnt    <= w_arb_gnt;
        r_last   <= w_idx;
        r_pwrite <= w_pwrite;
        r_paddr  <= w_paddr;
        r_pstrb  <= w_pstrb;
        r_pwdata <= w_pwdata;
      end else if (w_next == IDLE) begin
        r_gnt <= '0;
      end
    end
  end

  assign m_PSEL    = r_psel;
  assign m_PENABLE = r_pen;
  assign m_PWRITE  = r_pwrite;
  assign m_PADDR   = r_paddr;
  assign m_PSTRB   = r_pstrb;
  assign m_PWDATA  = r_pwdata;
  assign gnt_o     = r_gnt;

  assign s_PRDATA  = m_PRDATA;
  assign s_PREADY  = w_done ? r_gnt : '0;
  assign s_PSLVERR = s_PREADY & {MASTERS{m_PSLVERR}};

endmodule

// File: doc/apb_gpio_arb.md
# apb_gpio_arb

Round-robin APB4 arbiter that shares a single APB4 slave (typically the GPIO block) between `MASTERS` APB4 requesters. Each requester sees a normal APB4 slave port and is held with `PREADY=0` until granted. The arbiter then replays the winner's transfer on one APB4 master port toward the shared slave and returns `PRDATA`/`PSLVERR`. It sits between the CPU/DMA/debug APB bridges and the peripheral's `PSEL`.

## Interface
- `MASTERS`, 2, number of requesters (2..8)
- `PADDR_SIZE`, 4, address width
- `PDATA_SIZE`, 8, data width; multiple of 8
- `PRESETn`  in  1  reset; asynchronous, active-low
- `PCLK`  in  1  clock; all logic on the rising edge
- `s_PSEL`  in  MASTERS  per-requester select
- `s_PENABLE`  in  MASTERS  per-requester enable
- `s_PADDR`  in  MASTERS*PADDR_SIZE  packed; requester n at `[n*PADDR_SIZE +: PADDR_SIZE]`
- `s_PWRITE`  in  MASTERS  per-requester write
- `s_PSTRB`  in  MASTERS*PDATA_SIZE/8  packed byte strobes
- `s_PWDATA`  in  MASTERS*PDATA_SIZE  packed write data
- `s_PRDATA`  out  PDATA_SIZE  broadcast of `m_PRDATA`
- `s_PREADY`  out  MASTERS  per-requester ready
- `s_PSLVERR`  out  MASTERS  per-requester error; valid with `s_PREADY`
- `m_PSEL`, `m_PENABLE`, `m_PWRITE`  out  1  to the shared slave
- `m_PADDR`  out  PADDR_SIZE  to the shared slave
- `m_PSTRB`  out  PDATA_SIZE/8  to the shared slave
- `m_PWDATA`  out  PDATA_SIZE  to the shared slave
- `m_PRDATA`  in  PDATA_SIZE  from the shared slave
- `m_PREADY`, `m_PSLVERR`  in  1  from the shared slave
- `gnt_o`  out  MASTERS  one-hot current grant; 0 when IDLE

## Operation
**FSM states:** IDLE, SETUP, ACCESS.
- **IDLE:** request vector is `s_PSEL`. If any bit is set:
  - Pick the winner round-robin: search starts at index `last+1` and wraps.
  - Register `gnt_o`, `last`, and the winner's `PADDR`/`PWRITE`/`PSTRB`/`PWDATA` into the m-side registers.
  - Go to SETUP.
- **SETUP:** `m_PSEL=1`, `m_PENABLE=0`. Unconditionally go to ACCESS.
- **ACCESS:** `m_PSEL=1`, `m_PENABLE=1`.
  - Wait states: while `m_PREADY=0`, stay in ACCESS.
  - Completion: when `m_PREADY=1`:
    - `s_PREADY[g]=m_PREADY`, combinational.
    - `s_PSLVERR[g]=m_PSLVERR`, combinational.
    - Next state is SETUP if `s_PSEL` has another requester pending. The new winner is arbitrated in this same cycle, excluding g's current transfer.
    - Otherwise the next state is IDLE.
- **Non-granted requesters:** `s_PREADY=0`, `s_PSLVERR=0` at all times.
- **`s_PRDATA`:** driven from `m_PRDATA` to all requesters; only meaningful for the requester whose `s_PREADY=1`.
- **Pointer reset:** `last = MASTERS-1`, so requester 0 wins first after reset.
- **Fairness:** a requester that is pending while others complete is granted within `MASTERS-1` transfers.
- **Dropped request:** a requester that drops `s_PSEL` before it is granted is not arbitrated; no m-side transfer is issued for it.
- **Protocol violation:** the granted requester drops `s_PSEL` before completion. The m-side transfer still completes. `s_PREADY` pulses, and the result is discarded.
- **Simultaneous requests:** resolved purely by the round-robin pointer.

## Timing
- **Reset values:** while `PRESETn=0`, asynchronously:
  - FSM in IDLE.
  - `m_PSEL`, `m_PENABLE`, `m_PWRITE`, `m_PADDR`, `m_PSTRB`, `m_PWDATA` = 0.
  - `gnt_o` = 0.
  - `s_PREADY`, `s_PSLVERR` = 0.
  - `last = MASTERS-1`.
- **Reset mid-transfer:** abandons the transfer; no `s_PREADY` is issued.
- **m-side registers:** all m-side outputs are registered. `m_PADDR`, `m_PWRITE`, `m_PSTRB`, `m_PWDATA` are stable from SETUP through the completing ACCESS cycle.
- **Uncontended latency:** with `s_PSEL` at cycle 0 and a zero-wait slave:
  - m-side SETUP at cycle 1.
  - ACCESS at cycle 2, with `s_PREADY=1` in cycle 2.
  - The requester sees exactly one wait state.
- **Back-to-back:** the next m-side SETUP follows the completing ACCESS with no IDLE cycle, giving 2 cycles per transfer sustained.
- **Slave wait states:** each cycle of `m_PREADY=0` adds one cycle to the requester's transfer.

## Structure
- **Shared package `apb_arb_pkg`:**
  - `typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_arb_state_t`.
  - `function` for packed-slice extraction.
- **Sub-module `rr_arbiter`:**
  - Parameter `N`.
  - Inputs: `req[N]`, `last[$clog2(N)]`.
  - Output: one-hot `gnt[N]`.
  - Purely combinational.
  - The top holds the FSM and the `last` register.

## Test plan
1. **Single requester:** requester 0 writes `PADDR=2`, `PWDATA=8'hA5`, `PSTRB=1`, zero-wait slave.
   - `m_PSEL` rises at cycle 1, `m_PENABLE` at cycle 2, with `m_PADDR=2`, `m_PWDATA=8'hA5`.
   - `s_PREADY[0]=1` at cycle 2.
2. **Contention:** requesters 0 and 1 assert `s_PSEL` in the same cycle after reset.
   - Requester 0 completes first; requester 1's SETUP is on the next cycle.
   - `gnt_o` sequence: `01`, `10`.
   - `s_PREADY[1]` stays 0 until its own ACCESS.
3. **Fairness:** both requesters issue 4 continuous back-to-back reads.
   - Grants strictly alternate `0,1,0,1,…`.
   - Every transfer is 2 cycles on the m-side.
4. **Slave wait and error:** slave holds `m_PREADY=0` for 3 cycles, then returns `m_PSLVERR=1`, `m_PRDATA=8'h3C`.
   - Winner sees `s_PREADY`=1, `s_PSLVERR`=1 and `s_PRDATA=8'h3C` in the 4th ACCESS cycle.
   - The other requester sees `s_PSLVERR=0`.
5. **Reset mid-transfer:** assert `PRESETn=0` during ACCESS.
   - `m_PSEL`, `m_PENABLE`, `gnt_o`, `s_PREADY` drop to 0 immediately.
   - After release, requester 0 wins first.
